// File: rtl/clock_hms_alarm.sv
// Hours/minutes/seconds clock with a 12 h or 24 h hour format, set/hold/run modes and an alarm.
// The ringing output stays high for a fixed number of clk_1Hz ticks after a match.
module clock_hms_alarm #(
  parameter bit CLOCK_24H  = 1'b0,
  parameter int RING_TICKS = 30,
  parameter int RING_W     = 8
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       run,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       alarm_en,
  input  logic       hour_in,
  input  logic       min_in,
  input  logic       sec_in,
  output logic [4:0] hour_out,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       pm_out,
  output logic [4:0] alarm_hour_out,
  output logic [5:0] alarm_min_out,
  output logic       alarm_pm_out,
  output logic       ringing,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2,
    RUN       = 2'd3
  } state_t;

  typedef struct packed {
    logic       pm;
    logic [4:0] hr;
  } hour_t;

  localparam logic [4:0]        HOUR_RST  = CLOCK_24H ? 5'd0 : 5'd12;
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_TICKS - 1);

  // Shared by set-mode pulses and the running carry: 12 h wraps 12->1 and flips pm on 11->12.
  function automatic hour_t hour_inc(input hour_t cur);
    hour_t nxt;
    nxt = cur;
    if (CLOCK_24H) begin
      nxt.pm = 1'b0;
      nxt.hr = (cur.hr == 5'd23) ? 5'd0 : cur.hr + 5'd1;
    end else if (cur.hr == 5'd12) begin
      nxt.hr = 5'd1;
    end else if (cur.hr == 5'd11) begin
      nxt.hr = 5'd12;
      nxt.pm = ~cur.pm;
    end else begin
      nxt.hr = cur.hr + 5'd1;
    end
    return nxt;
  endfunction

  function automatic logic [5:0] inc59(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  state_t            state_q, state_d;
  hour_t             hour_q, hour_d;
  logic [5:0]        min_q, min_d;
  logic [5:0]        sec_q, sec_d;
  hour_t             alarm_hour_q, alarm_hour_d;
  logic [5:0]        alarm_min_q, alarm_min_d;
  logic              ring_q, ring_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic              alarm_match;

  assign alarm_match = (state_q == RUN) && alarm_en && (sec_q == 6'd0) &&
                       (hour_q == alarm_hour_q) && (min_q == alarm_min_q);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a latch behind.
    state_d      = state_q;
    hour_d       = hour_q;
    min_d        = min_q;
    sec_d        = sec_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    ring_d       = ring_q;
    ring_cnt_d   = ring_cnt_q;

    case (state_q)
      IDLE: begin
        if (set_alarm)     state_d = SET_ALARM;
        else if (set_time) state_d = SET_TIME;
        else if (run)      state_d = RUN;
      end
      SET_TIME: begin
        if (!set_time) state_d = IDLE;
        if (hour_in)   hour_d  = hour_inc(hour_q);
        if (min_in)    min_d   = inc59(min_q);
        if (sec_in)    sec_d   = inc59(sec_q);
      end
      SET_ALARM: begin
        if (!set_alarm) state_d      = IDLE;
        if (hour_in)    alarm_hour_d = hour_inc(alarm_hour_q);
        if (min_in)     alarm_min_d  = inc59(alarm_min_q);
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
        end else begin
          sec_d = inc59(sec_q);
          if (sec_q == 6'd59) begin
            min_d = inc59(min_q);
            if (min_q == 6'd59) hour_d = hour_inc(hour_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An active ring runs out its count; a new match cannot restart it.
    if (!alarm_en || state_q != RUN || state_d != RUN) begin
      ring_d     = 1'b0;
      ring_cnt_d = '0;
    end else if (ring_q) begin
      if (ring_cnt_q == '0) ring_d     = 1'b0;
      else                  ring_cnt_d = ring_cnt_q - 1'b1;
    end else if (alarm_match) begin
      ring_d     = 1'b1;
      ring_cnt_d = RING_LOAD;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hour_q       <= '{pm: 1'b0, hr: HOUR_RST};
      min_q        <= '0;
      sec_q        <= '0;
      alarm_hour_q <= '{pm: 1'b0, hr: HOUR_RST};
      alarm_min_q  <= '0;
      ring_q       <= 1'b0;
      ring_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      ring_q       <= ring_d;
      ring_cnt_q   <= ring_cnt_d;
    end
  end

  assign hour_out       = hour_q.hr;
  assign pm_out         = hour_q.pm;
  assign min_out        = min_q;
  assign sec_out        = sec_q;
  assign alarm_hour_out = alarm_hour_q.hr;
  assign alarm_pm_out   = alarm_hour_q.pm;
  assign alarm_min_out  = alarm_min_q;
  assign ringing        = ring_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_clock_hms_alarm.sv
// Directed bench for clock_hms_alarm: a 12 h and a 24 h instance share the same stimulus,
// and each phase checks whichever instance the scenario targets.
module tb_clock_hms_alarm;

  logic clk_1Hz = 1'b0;
  logic reset, run, set_time, set_alarm, alarm_en, hour_in, min_in, sec_in;

  logic [4:0] hr12, ahr12, hr24, ahr24;
  logic [5:0] mn12, sc12, amn12, mn24, sc24, amn24;
  logic       pm12, apm12, ring12, pm24, apm24, ring24;
  logic [1:0] st12, st24;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  clock_hms_alarm #(.CLOCK_24H(1'b0), .RING_TICKS(5), .RING_W(8)) u12 (
    .clk_1Hz(clk_1Hz), .reset(reset), .run(run), .set_time(set_time), .set_alarm(set_alarm),
    .alarm_en(alarm_en), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_out(hr12), .min_out(mn12), .sec_out(sc12), .pm_out(pm12),
    .alarm_hour_out(ahr12), .alarm_min_out(amn12), .alarm_pm_out(apm12),
    .ringing(ring12), .state_out(st12)
  );

  clock_hms_alarm #(.CLOCK_24H(1'b1), .RING_TICKS(5), .RING_W(8)) u24 (
    .clk_1Hz(clk_1Hz), .reset(reset), .run(run), .set_time(set_time), .set_alarm(set_alarm),
    .alarm_en(alarm_en), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_out(hr24), .min_out(mn24), .sec_out(sc24), .pm_out(pm24),
    .alarm_hour_out(ahr24), .alarm_min_out(amn24), .alarm_pm_out(apm24),
    .ringing(ring24), .state_out(st24)
  );

  // {pm, hour, min, sec}
  logic [17:0] t12, t24;
  assign t12 = {pm12, hr12, mn12, sc12};
  assign t24 = {pm24, hr24, mn24, sc24};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; set_time = 1'b0; set_alarm = 1'b0; alarm_en = 1'b0;
    hour_in = 1'b0; min_in = 1'b0; sec_in = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_time_to(input int h, input int m, input int s);
    set_time = 1'b1; tick();
    hour_in = 1'b1; repeat (h) tick(); hour_in = 1'b0;
    min_in  = 1'b1; repeat (m) tick(); min_in  = 1'b0;
    sec_in  = 1'b1; repeat (s) tick(); sec_in  = 1'b0;
    set_time = 1'b0; tick();
  endtask

  // Alarm 7:00 AM, time 6:59:58 AM, run until 7:00:00 is on the outputs.
  task automatic alarm_setup();
    do_reset();
    set_alarm = 1'b1; tick();
    hour_in = 1'b1; repeat (7) tick(); hour_in = 1'b0;
    sec_in = 1'b1; tick(); sec_in = 1'b0;
    check("alarm_sec_ignored", sc12, 0);
    set_alarm = 1'b0; tick();
    check("alarm_regs", {apm12, ahr12, amn12}, {1'b0, 5'd7, 6'd0});
    set_time_to(6, 59, 58);
    alarm_en = 1'b1; run = 1'b1;
    tick(); tick(); tick();
    check("alarm_time_700", t12, {1'b0, 5'd7, 6'd0, 6'd0});
    check("ring_not_yet", ring12, 0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; set_time = 1'b0; set_alarm = 1'b0; alarm_en = 1'b0;
    hour_in = 1'b0; min_in = 1'b0; sec_in = 1'b0;
    #2;
    check("rst_state12", {st12, ring12}, 0);
    check("rst_time12", t12, {1'b0, 5'd12, 6'd0, 6'd0});
    check("rst_time24", t24, 0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_hold", {st12, t12, ring12}, {2'd0, 1'b0, 5'd12, 6'd0, 6'd0, 1'b0});
    end

    // Time editing
    set_time = 1'b1; tick();
    check("enter_set_time", st12, 1);
    hour_in = 1'b1; repeat (11) tick(); hour_in = 1'b0;
    check("hour_x11_12h", {pm12, hr12}, {1'b0, 5'd11});
    check("hour_x11_24h", {pm24, hr24}, {1'b0, 5'd11});
    hour_in = 1'b1; tick(); hour_in = 1'b0;
    check("hour_11_to_12pm", {pm12, hr12}, {1'b1, 5'd12});
    check("hour_11_to_12_24h", {pm24, hr24}, {1'b0, 5'd12});
    min_in = 1'b1; repeat (59) tick(); min_in = 1'b0;
    check("min_59", mn12, 59);
    min_in = 1'b1; tick(); min_in = 1'b0;
    check("min_wrap_no_carry", t12, {1'b1, 5'd12, 6'd0, 6'd0});
    sec_in = 1'b1; repeat (3) tick(); sec_in = 1'b0;
    check("sec_edit", t12, {1'b1, 5'd12, 6'd0, 6'd3});
    hour_in = 1'b1; min_in = 1'b1; sec_in = 1'b1; tick();
    hour_in = 1'b0; min_in = 1'b0; sec_in = 1'b0;
    check("simul_12h", t12, {1'b1, 5'd1, 6'd1, 6'd4});
    check("simul_24h", t24, {1'b0, 5'd13, 6'd1, 6'd4});
    set_time = 1'b0; tick();
    check("exit_set_time", st12, 0);

    // 12 h running rollovers
    do_reset();
    set_time_to(11, 59, 58);
    check("preset_115958", {st12, t12}, {2'd0, 1'b0, 5'd11, 6'd59, 6'd58});
    run = 1'b1; tick();
    check("enter_run_no_adv", {st12, t12}, {2'd3, 1'b0, 5'd11, 6'd59, 6'd58});
    tick();
    check("run_115959am", t12, {1'b0, 5'd11, 6'd59, 6'd59});
    tick();
    check("run_120000pm", t12, {1'b1, 5'd12, 6'd0, 6'd0});
    check("run_120000_24h", t24, {1'b0, 5'd12, 6'd0, 6'd0});
    repeat (3599) tick();
    check("run_125959pm", t12, {1'b1, 5'd12, 6'd59, 6'd59});
    tick();
    check("run_010000pm", t12, {1'b1, 5'd1, 6'd0, 6'd0});
    check("run_130000_24h", t24, {1'b0, 5'd13, 6'd0, 6'd0});
    run = 1'b0; tick();

    // 24 h midnight rollover and hold
    do_reset();
    set_time_to(23, 59, 59);
    check("preset_235959", t24, {1'b0, 5'd23, 6'd59, 6'd59});
    run = 1'b1; tick(); tick();
    check("run_000000_24h", t24, 0);
    repeat (3) tick();
    check("run_000003_24h", t24, {1'b0, 5'd0, 6'd0, 6'd3});
    run = 1'b0; tick();
    check("hold_state", st24, 0);
    check("hold_no_adv", t24, {1'b0, 5'd0, 6'd0, 6'd3});
    repeat (3) tick();
    check("hold_frozen", t24, {1'b0, 5'd0, 6'd0, 6'd3});

    // Alarm ring length
    alarm_setup();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ring_high", ring12, 1);
    end
    tick();
    check("ring_done", ring12, 0);

    // Reset mid-ring
    alarm_setup();
    tick(); tick();
    check("ring_before_rst", ring12, 1);
    reset = 1'b1; #1;
    check("async_rst_ring", ring12, 0);
    check("async_rst_time", {st12, t12}, {2'd0, 1'b0, 5'd12, 6'd0, 6'd0});
    tick();
    reset = 1'b0;

    // Disarm mid-ring
    alarm_setup();
    tick(); tick();
    check("ring_before_disarm", ring12, 1);
    alarm_en = 1'b0; tick();
    check("disarm_ring_off", ring12, 0);
    check("disarm_still_run", {st12, t12}, {2'd3, 1'b0, 5'd7, 6'd0, 6'd3});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
